// File: rtl/rts_pkg.sv
// Shared definitions for the RTS/RTR stream source and its matching checker.
package rts_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int LFSR_W = 16;
   // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/rts_pace_gen.sv
// Pacing for the stream source: cumulative rate credit plus periodic dropout windows.
module rts_pace_gen
   import rts_pkg::*;
#(
   parameter int LOAD_PER  = 10,
   parameter int DROP_PER  = 100,
   parameter int DROP_DUTY = 90
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   input  logic xfc,
   output logic eligible
);

   localparam int DW = (DROP_PER > 1) ? $clog2(DROP_PER) : 1;

   logic [31:0]   active_cnt_reg;
   logic [31:0]   slot_reg;
   logic [31:0]   slot_next;
   logic [DW-1:0] drop_cnt_reg;

   // Credit is compared against the slot after this cycle's transfer is charged.
   assign slot_next = slot_reg + (xfc ? 32'(LOAD_PER) : 32'd0);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         active_cnt_reg <= '0;
         slot_reg       <= '0;
         drop_cnt_reg   <= '0;
      end else if (run) begin
         active_cnt_reg <= active_cnt_reg + 32'd1;
         slot_reg       <= slot_next;
         drop_cnt_reg   <= (drop_cnt_reg == DW'(DROP_PER - 1)) ? '0 : drop_cnt_reg + DW'(1);
      end
   end

   assign eligible = run && (drop_cnt_reg >= DW'(DROP_DUTY)) && (active_cnt_reg >= slot_next);

endmodule

// File: rtl/rts_stream_src.sv
// Self-contained RTS/RTR word source: counts out a programmed number of words
// (incrementing or LFSR data) under pacing, then reports done.
module rts_stream_src
   import rts_pkg::*;
#(
   parameter int              WORDLENGTH = 8,
   parameter int              CNT_W      = 16,
   parameter int              LOAD_PER   = 10,
   parameter int              DROP_PER   = 100,
   parameter int              DROP_DUTY  = 90,
   parameter logic [15:0]     LFSR_SEED  = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CNT_W-1:0]      target,
   input  logic                  rnd_mode,
   output logic                  OUT_RTS,
   input  logic                  OUT_RTR,
   output logic [WORDLENGTH-1:0] OUT_DAT,
   output logic [CNT_W-1:0]      sent_count,
   output logic                  busy,
   output logic                  done
);

   state_t                state_reg, state_next;
   logic [CNT_W-1:0]      target_reg, target_next;
   logic [CNT_W-1:0]      sent_reg, sent_next;
   logic                  mode_reg, mode_next;
   logic [LFSR_W-1:0]     lfsr_reg, lfsr_next_val;
   logic                  rts_reg, rts_next;
   logic [WORDLENGTH-1:0] dat_reg, dat_next;
   logic                  run, accept, xfc, eligible;

   assign run    = (state_reg == RUN);
   assign accept = start && (state_reg != RUN);
   assign xfc    = rts_reg && OUT_RTR;

   rts_pace_gen #(
      .LOAD_PER  (LOAD_PER),
      .DROP_PER  (DROP_PER),
      .DROP_DUTY (DROP_DUTY)
   ) u_pace (
      .clk      (clk),
      .reset    (reset),
      .clear    (accept),
      .run      (run),
      .xfc      (xfc),
      .eligible (eligible)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         target_reg <= '0;
         sent_reg   <= '0;
         mode_reg   <= 1'b0;
         lfsr_reg   <= LFSR_SEED;
         rts_reg    <= 1'b0;
         dat_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         target_reg <= target_next;
         sent_reg   <= sent_next;
         mode_reg   <= mode_next;
         lfsr_reg   <= lfsr_next_val;
         rts_reg    <= rts_next;
         dat_reg    <= dat_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      target_next   = target_reg;
      sent_next     = sent_reg;
      mode_next     = mode_reg;
      lfsr_next_val = lfsr_reg;

      if (accept) begin
         target_next   = target;
         mode_next     = rnd_mode;
         sent_next     = '0;
         lfsr_next_val = LFSR_SEED;
      end else if (run && xfc && (sent_reg < target_reg)) begin
         sent_next     = sent_reg + CNT_W'(1);
         lfsr_next_val = lfsr_next(lfsr_reg);
      end

      case (state_reg)
         IDLE, DONE: if (start) state_next = RUN;
         RUN:        if (sent_next >= target_reg) state_next = DONE;
         default:    state_next = IDLE;
      endcase

      // An unaccepted offer is held as-is; a new one needs fresh eligibility.
      rts_next = run && (sent_next < target_reg) && ((rts_reg && !OUT_RTR) || eligible);
      dat_next = mode_next ? lfsr_next_val[WORDLENGTH-1:0] : sent_next[WORDLENGTH-1:0];
   end

   assign OUT_RTS    = rts_reg;
   assign OUT_DAT    = dat_reg;
   assign sent_count = sent_reg;
   assign busy       = run;
   assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_rts_stream_src.sv
// Directed bench for rts_stream_src: three instances cover unpaced, paced and dropout behaviour.
module tb_rts_stream_src;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] target;
   logic        rnd_mode;

   logic       start_a, rtr_a, rts_a, busy_a, done_a;
   logic [7:0] dat_a;
   logic [15:0] sent_a;
   logic       start_b, rtr_b, rts_b, busy_b, done_b;
   logic [7:0] dat_b;
   logic [15:0] sent_b;
   logic       start_c, rtr_c, rts_c, busy_c, done_c;
   logic [7:0] dat_c;
   logic [15:0] sent_c;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   logic [7:0] lfsr_exp [5] = '{8'hE1, 8'h70, 8'h38, 8'h9C, 8'hCE};

   always #5 clk = ~clk;

   rts_stream_src #(.WORDLENGTH(8), .CNT_W(16), .LOAD_PER(1), .DROP_PER(100), .DROP_DUTY(0),
                    .LFSR_SEED(16'hACE1)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .target(target), .rnd_mode(rnd_mode),
      .OUT_RTS(rts_a), .OUT_RTR(rtr_a), .OUT_DAT(dat_a), .sent_count(sent_a),
      .busy(busy_a), .done(done_a));

   rts_stream_src #(.WORDLENGTH(8), .CNT_W(16), .LOAD_PER(10), .DROP_PER(100), .DROP_DUTY(0),
                    .LFSR_SEED(16'hACE1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .target(target), .rnd_mode(rnd_mode),
      .OUT_RTS(rts_b), .OUT_RTR(rtr_b), .OUT_DAT(dat_b), .sent_count(sent_b),
      .busy(busy_b), .done(done_b));

   rts_stream_src #(.WORDLENGTH(8), .CNT_W(16), .LOAD_PER(10), .DROP_PER(100), .DROP_DUTY(90),
                    .LFSR_SEED(16'hACE1)) dut_c (
      .clk(clk), .reset(reset), .start(start_c), .target(target), .rnd_mode(rnd_mode),
      .OUT_RTS(rts_c), .OUT_RTR(rtr_c), .OUT_DAT(dat_c), .sent_count(sent_c),
      .busy(busy_c), .done(done_c));

   always @(negedge clk) begin
      if (!reset && rts_a && rtr_a) $display("xfc a: dat=%02h sent=%0d", dat_a, sent_a);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, xcnt, first, last, gap_err, pairs, viol;
      logic prev;

      reset = 1'b1; target = '0; rnd_mode = 1'b0;
      start_a = 0; start_b = 0; start_c = 0;
      rtr_a = 1; rtr_b = 1; rtr_c = 1;
      tick(); tick();
      check("rst_rts", rts_a, 0);
      check("rst_dat", dat_a, 0);
      check("rst_sent", sent_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      reset = 1'b0;
      tick();

      // Unpaced incrementing run
      target = 5; rnd_mode = 0; start_a = 1; tick(); start_a = 0;
      check("start_busy", busy_a, 1);
      check("start_rts_low", rts_a, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("inc_rts", rts_a, 1);
         check("inc_dat", dat_a, i);
         tick();
      end
      check("inc_done", done_a, 1);
      check("inc_sent", sent_a, 5);
      check("inc_rts_off", rts_a, 0);
      check("inc_busy_off", busy_a, 0);
      tick();
      check("inc_rts_stays_off", rts_a, 0);

      // Backpressure with an ignored start in the middle
      target = 3; start_a = 1; tick(); start_a = 0; tick();
      rtr_a = 0;
      for (int i = 0; i < 7; i++) begin
         check("bp_rts_hold", rts_a, 1);
         check("bp_dat_hold", dat_a, 0);
         start_a = (i == 3);
         tick();
      end
      start_a = 0;
      check("run_start_sent", sent_a, 0);
      check("run_start_busy", busy_a, 1);
      rtr_a = 1;
      tick();
      check("bp_resume1_rts", rts_a, 1);
      check("bp_resume1_dat", dat_a, 1);
      tick();
      check("bp_resume2_dat", dat_a, 2);
      tick();
      check("bp_done", done_a, 1);
      check("bp_sent", sent_a, 3);

      // LFSR mode, run twice to confirm restart reproduces the sequence
      for (int r = 0; r < 2; r++) begin
         target = 5; rnd_mode = 1; start_a = 1; tick(); start_a = 0; rnd_mode = 0;
         tick();
         for (int i = 0; i < 5; i++) begin
            check("lfsr_rts", rts_a, 1);
            check("lfsr_dat", dat_a, lfsr_exp[i]);
            tick();
         end
         check("lfsr_done", done_a, 1);
      end

      // Zero-length target
      target = 0; start_a = 1; tick(); start_a = 0;
      check("t0_busy", busy_a, 1);
      check("t0_rts", rts_a, 0);
      tick();
      check("t0_done", done_a, 1);
      check("t0_rts_after", rts_a, 0);
      check("t0_sent", sent_a, 0);

      // Reset in the middle of a run with an offer pending
      target = 5; start_a = 1; tick(); start_a = 0; tick(); tick();
      check("mid_rts", rts_a, 1);
      check("mid_sent", sent_a, 1);
      reset = 1; tick();
      check("mid_rst_rts", rts_a, 0);
      check("mid_rst_dat", dat_a, 0);
      check("mid_rst_sent", sent_a, 0);
      check("mid_rst_busy", busy_a, 0);
      check("mid_rst_done", done_a, 0);
      reset = 0; tick();

      // Pacing: one transfer every 10 cycles
      target = 100; start_b = 1; tick(); start_b = 0;
      t = 0; xcnt = 0; first = 0; last = 0; gap_err = 0;
      while (!done_b && t < 1500) begin
         tick(); t++;
         if (rts_b) begin
            xcnt++;
            if (xcnt == 1) first = t;
            else if (t - last != 10) gap_err++;
            last = t;
         end
      end
      check("pace_first", first, 1);
      check("pace_count", xcnt, 100);
      check("pace_gaps", gap_err, 0);
      check("pace_done_cycle", t, 992);
      check("pace_sent", sent_b, 100);

      // Dropout windows with catch-up bursts
      target = 20; start_c = 1; tick(); start_c = 0;
      t = 0; xcnt = 0; first = 0; pairs = 0; viol = 0; prev = 0;
      while (!done_c && t < 1000) begin
         tick(); t++;
         if (rts_c && !prev && ((t - 1) % 100) < 90) viol++;
         if (rts_c) begin
            xcnt++;
            if (first == 0) first = t;
            if (prev) pairs++;
         end
         prev = rts_c;
      end
      check("drop_first", first, 91);
      check("drop_viol", viol, 0);
      check("drop_count", xcnt, 20);
      check("drop_burst_pairs", pairs, 18);
      check("drop_done_cycle", t, 201);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
